chain_frame_sched: RTL and testbench
====================================

# chain_frame_sched

Frame scheduler between the chain-code encoder and the byte-serial transmitter in the FPGA image-contour pipeline. It launches and re-arms the encoder, drains its chain codes one byte at a time over a valid/ready link, and wraps them in a framed packet with start coordinates, perimeter and area. It also recovers the encoder from error and stall conditions by pulsing a dedicated encoder reset.

## Interface
- SOF, 8'hA5, start-of-frame marker byte
- EOF, 8'h5A, end-of-codes marker byte (codes are always < 8, so this value is never ambiguous)
- TIMEOUT_CYCLES, 65535, stall limit for waiting states; counter is 16 bits
- clk  in  1  clock; all logic on the rising edge
- reset  in  1  asynchronous, active-high
- go  in  1  frame request; sampled only in IDLE
- enc_start  out  1  one-cycle start pulse to the encoder
- enc_rst  out  1  one-cycle reset pulse to the encoder, issued at frame end or abort
- enc_ready  in  1  encoder has a code on enc_code (level)
- enc_code  in  8  chain code byte
- enc_code_ack  out  1  one-cycle pulse: code consumed (drives the encoder's sender_done)
- enc_done  in  1  encoder has sent all codes
- enc_error  in  1  encoder found no object
- enc_perimeter  in  8  perimeter count
- enc_area  in  12  area count
- enc_start_row, enc_start_col  in  7 each  contour start coordinate
- tx_valid  out  1  tx_data is valid
- tx_data  out  8  frame byte
- tx_ready  in  1  transmitter accepts the byte
- busy  out  1  high in every state except IDLE
- frame_done  out  1  one-cycle pulse on a successful frame
- frame_error  out  1  sticky; cleared by the next accepted go
- byte_count  out  9  number of bytes transferred in the current frame

## Operation
- A byte transfers on a clock edge where tx_valid and tx_ready are both high.
- Once tx_valid is asserted, tx_data is held stable and tx_valid stays high until the byte transfers.
- Frame layout, in order:
  - SOF, {1'b0,start_row}, {1'b0,start_col}
  - one byte per code (enc_code passed through unchanged)
  - EOF, perimeter, {4'b0,area[11:8]}, area[7:0]
- State machine:
  - IDLE: on go, clear frame_error and byte_count, pulse enc_start, go to WAIT_FIRST.
  - WAIT_FIRST:
    - enc_error: go to ABORT.
    - enc_ready: latch start_row and start_col, go to HDR.
    - Timeout: go to ABORT.
  - HDR: send SOF, row, col (index 0..2), then go to CODE_SEND.
  - CODE_SEND:
    - Capture enc_code into the tx register and present it on tx_data.
    - On transfer: pulse enc_code_ack, go to REARM.
  - REARM: wait for enc_ready=0, then go to CODE_WAIT.
  - CODE_WAIT:
    - enc_ready: go to CODE_SEND.
    - enc_done: latch perimeter and area, go to TRL.
    - Timeout: go to ABORT.
  - TRL: send EOF, perimeter, area_hi, area_lo (plus the checksum byte when configured), then go to FIN.
  - FIN: pulse enc_rst and frame_done, go to IDLE.
  - ABORT: set frame_error, pulse enc_rst, drop tx_valid (only possible in waiting states, where tx_valid is already low), go to IDLE.
- enc_done is ignored outside CODE_WAIT; enc_error is ignored outside WAIT_FIRST.
- go is ignored while busy.
- Timeout counter: zeroed on entry to WAIT_FIRST or CODE_WAIT; reaching TIMEOUT_CYCLES triggers ABORT. It does not run while a byte waits for tx_ready.
- byte_count increments on each transfer and saturates at 511.

## Timing
- Reset values: all outputs 0; state IDLE.
- Reset mid-frame: takes effect immediately with no trailing bytes; no enc_rst pulse is generated.
- go sampled at edge N: busy=1 and enc_start=1 during cycle N+1.
- Header: enc_ready seen at edge M gives tx_valid=1 with SOF from M+1.
- Zero-wait transmitter: one byte per cycle within the header and trailer; each code costs at least 3 cycles (send, ack, rearm).
- enc_code_ack is asserted in the cycle immediately after the code's transfer edge, for exactly one cycle.
- If enc_ready and enc_done are both high in CODE_WAIT, enc_ready wins.
- frame_done and enc_rst are asserted together, in the cycle after the last trailer byte's transfer edge.

## Configuration
- CHAIN_FRAME_CHECKSUM_EN:
  - Defined: one extra byte is appended after area_lo. It is the XOR of every byte from start_row through area_lo, excluding SOF and EOF.
  - Undefined: no checksum byte, no checksum logic, and the frame ends at area_lo.

## Test plan
- Stub encoder (row 3, col 5, codes 0,6,4,2, perimeter 4, area 4), tx_ready=1 -> bytes A5 03 05 00 06 04 02 5A 04 00 04; byte_count=11; one frame_done pulse; one enc_rst pulse; four enc_code_ack pulses.
- Same stub, tx_ready low for 10 cycles while code 06 is presented -> tx_data stays 06; no enc_code_ack until the transfer; no timeout.
- enc_error=1 in WAIT_FIRST -> no tx_valid; frame_error=1; enc_rst pulse; state IDLE. The next go clears frame_error.
- TIMEOUT_CYCLES=16, enc_ready never rises -> ABORT 16 cycles after entry to WAIT_FIRST, frame_error=1, byte_count=0.
- Reset asserted mid-code with tx_valid=1 -> tx_valid, busy and byte_count are 0 immediately; no further bytes after release.
- CHAIN_FRAME_CHECKSUM_EN defined, first stub -> trailer ends 04 00 04 06; byte_count=12.

Source files
------------

// File: rtl/chain_frame_sched.sv
// Frame scheduler: launches the chain-code encoder, drains its codes over a valid/ready byte link
// and wraps them in SOF/header/EOF/trailer framing. Define CHAIN_FRAME_CHECKSUM_EN for a trailing XOR byte.
module chain_frame_sched #(
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        go,
  output logic        enc_start,
  output logic        enc_rst,
  input  logic        enc_ready,
  input  logic [7:0]  enc_code,
  output logic        enc_code_ack,
  input  logic        enc_done,
  input  logic        enc_error,
  input  logic [7:0]  enc_perimeter,
  input  logic [11:0] enc_area,
  input  logic [6:0]  enc_start_row,
  input  logic [6:0]  enc_start_col,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        busy,
  output logic        frame_done,
  output logic        frame_error,
  output logic [8:0]  byte_count
);
  localparam logic [7:0]  SOF      = 8'hA5;
  localparam logic [7:0]  EOF      = 8'h5A;
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
`ifdef CHAIN_FRAME_CHECKSUM_EN
  localparam logic [2:0]  TRL_LAST = 3'd4;
`else
  localparam logic [2:0]  TRL_LAST = 3'd3;
`endif

  typedef enum logic [3:0] {
    IDLE, WAIT_FIRST, HDR, CODE_SEND, REARM, CODE_WAIT, TRL, FIN, ABORT
  } state_t;

  state_t      state, state_nxt;
  logic [2:0]  idx;
  logic [15:0] tmo_cnt;
  logic [6:0]  row, col;
  logic [7:0]  perim;
  logic [11:0] area;
  logic        xfer, tmo_hit;
`ifdef CHAIN_FRAME_CHECKSUM_EN
  logic [7:0]  cks;
`endif

  assign xfer       = tx_valid & tx_ready;
  assign tmo_hit    = (tmo_cnt == TMO_LAST);
  assign busy       = (state != IDLE);
  assign enc_rst    = (state == FIN) || (state == ABORT);
  assign frame_done = (state == FIN);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:       if (go) state_nxt = WAIT_FIRST;
      WAIT_FIRST: begin
        if (enc_error)      state_nxt = ABORT;
        else if (enc_ready) state_nxt = HDR;
        else if (tmo_hit)   state_nxt = ABORT;
      end
      HDR:        if (xfer && idx == 3'd2) state_nxt = CODE_SEND;
      CODE_SEND:  if (xfer) state_nxt = REARM;
      REARM:      if (!enc_ready) state_nxt = CODE_WAIT;
      CODE_WAIT: begin
        // a pending code beats enc_done so no code is ever dropped
        if (enc_ready)      state_nxt = CODE_SEND;
        else if (enc_done)  state_nxt = TRL;
        else if (tmo_hit)   state_nxt = ABORT;
      end
      TRL:        if (xfer && idx == TRL_LAST) state_nxt = FIN;
      FIN:        state_nxt = IDLE;
      ABORT:      state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enc_start    <= 1'b0;
      enc_code_ack <= 1'b0;
      tx_valid     <= 1'b0;
      tx_data      <= 8'd0;
      frame_error  <= 1'b0;
      byte_count   <= 9'd0;
      idx          <= 3'd0;
      tmo_cnt      <= 16'd0;
      row          <= 7'd0;
      col          <= 7'd0;
      perim        <= 8'd0;
      area         <= 12'd0;
`ifdef CHAIN_FRAME_CHECKSUM_EN
      cks          <= 8'd0;
`endif
    end else begin
      enc_start    <= (state == IDLE) && go;
      enc_code_ack <= (state == CODE_SEND) && xfer;
      // counter only runs in the two waiting states, so it is zero on every entry
      tmo_cnt      <= (state == WAIT_FIRST || state == CODE_WAIT) ? tmo_cnt + 16'd1 : 16'd0;
      if (xfer && byte_count != 9'd511) byte_count <= byte_count + 9'd1;
      if (state_nxt == ABORT) frame_error <= 1'b1;
`ifdef CHAIN_FRAME_CHECKSUM_EN
      if (xfer && !((state == HDR || state == TRL) && idx == 3'd0)) cks <= cks ^ tx_data;
`endif
      case (state)
        IDLE: if (go) begin
          frame_error <= 1'b0;
          byte_count  <= 9'd0;
`ifdef CHAIN_FRAME_CHECKSUM_EN
          cks         <= 8'd0;
`endif
        end
        WAIT_FIRST: if (!enc_error && enc_ready) begin
          row      <= enc_start_row;
          col      <= enc_start_col;
          tx_data  <= SOF;
          tx_valid <= 1'b1;
          idx      <= 3'd0;
        end
        HDR: if (xfer) begin
          idx <= idx + 3'd1;
          case (idx)
            3'd0:    tx_data <= {1'b0, row};
            3'd1:    tx_data <= {1'b0, col};
            default: tx_data <= enc_code;
          endcase
        end
        CODE_SEND: if (xfer) tx_valid <= 1'b0;
        CODE_WAIT: begin
          if (enc_ready) begin
            tx_data  <= enc_code;
            tx_valid <= 1'b1;
          end else if (enc_done) begin
            perim    <= enc_perimeter;
            area     <= enc_area;
            tx_data  <= EOF;
            tx_valid <= 1'b1;
            idx      <= 3'd0;
          end
        end
        TRL: if (xfer) begin
          idx <= idx + 3'd1;
          case (idx)
            3'd0:    tx_data <= perim;
            3'd1:    tx_data <= {4'b0, area[11:8]};
            3'd2:    tx_data <= area[7:0];
            default: ;
          endcase
`ifdef CHAIN_FRAME_CHECKSUM_EN
          // cks already holds row..area_hi; fold in area_lo as it leaves
          if (idx == 3'd3) tx_data <= cks ^ tx_data;
`endif
          if (idx == TRL_LAST) tx_valid <= 1'b0;
        end
        ABORT: tx_valid <= 1'b0;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_chain_frame_sched.sv
// Randomized bench for chain_frame_sched: stub encoder + transmitter, expected-byte queue model.
module tb_chain_frame_sched;
  logic        clk = 1'b0, reset = 1'b1, go = 1'b0;
  logic        enc_start, enc_rst, enc_code_ack, tx_valid, busy, frame_done, frame_error;
  logic        enc_ready, enc_done, enc_error, tx_ready;
  logic [7:0]  enc_code, enc_perimeter, tx_data;
  logic [11:0] enc_area;
  logic [6:0]  enc_start_row, enc_start_col;
  logic [8:0]  byte_count;

  always #5 clk = ~clk;

  chain_frame_sched #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .go(go), .enc_start(enc_start), .enc_rst(enc_rst),
    .enc_ready(enc_ready), .enc_code(enc_code), .enc_code_ack(enc_code_ack),
    .enc_done(enc_done), .enc_error(enc_error), .enc_perimeter(enc_perimeter),
    .enc_area(enc_area), .enc_start_row(enc_start_row), .enc_start_col(enc_start_col),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready), .busy(busy),
    .frame_done(frame_done), .frame_error(frame_error), .byte_count(byte_count));

  int checks = 0, errors = 0;
  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  typedef struct packed { logic [7:0] b; logic is_code; logic is_last; } ent_t;
  ent_t       exp_q[$];
  logic [7:0] got_q[$];

  // stub/transmitter configuration
  int         s_n = 0, s_mode = 0, s_maxdly = 0, tx_mode = 0, stall_left = 0;
  logic [7:0] s_codes [16];
  int         n_ack = 0, n_done = 0, n_rst = 0;

  // transmitter: 0 always ready, 1 random, 2 stall on the first 06 byte
  initial begin
    tx_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (tx_mode)
        0: tx_ready = 1'b1;
        1: tx_ready = ($urandom_range(3, 0) != 0);
        default: if (tx_valid && tx_data == 8'h06 && stall_left > 0) begin
          tx_ready = 1'b0; stall_left--;
        end else tx_ready = 1'b1;
      endcase
    end
  end

  // encoder stub
  task automatic enc_clear();
    enc_ready = 1'b0; enc_done = 1'b0; enc_error = 1'b0;
  endtask
  task automatic wcyc(int n, output bit ab);
    ab = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (reset) begin ab = 1'b1; return; end
    end
  endtask
  task automatic wait_rst();
    int t = 0;
    do begin @(negedge clk); t++; end while (!enc_rst && !reset && t < 500);
    chk("stub_rst_wait", enc_rst | reset, 1);
    @(posedge clk); #1;
  endtask
  task automatic enc_serve();
    bit ab;
    int t;
    wcyc(1 + $urandom_range(s_maxdly, 0), ab);
    if (ab) begin enc_clear(); return; end
    if (s_mode == 1) begin
      enc_error = 1'b1; wait_rst(); enc_clear(); return;
    end
    for (int i = 0; i < s_n; i++) begin
      if (i > 0) begin
        wcyc(1 + $urandom_range(s_maxdly, 0), ab);
        if (ab) begin enc_clear(); return; end
      end
      enc_code = s_codes[i]; enc_ready = 1'b1;
      t = 0;
      do begin @(negedge clk); t++; end while (!enc_code_ack && !reset && t < 500);
      if (reset) begin enc_clear(); return; end
      chk("stub_ack_wait", enc_code_ack, 1);
      @(posedge clk); #1; enc_ready = 1'b0;
    end
    wcyc(1 + $urandom_range(s_maxdly, 0), ab);
    if (ab) begin enc_clear(); return; end
    enc_done = 1'b1; wait_rst(); enc_clear();
  endtask
  initial begin
    enc_clear(); enc_code = 8'd0;
    forever begin
      @(negedge clk);
      if (reset || !enc_start || s_mode == 2) continue;
      enc_serve();
    end
  end

  // compare process: every cycle against the expected-byte queue
  initial begin
    logic       p_code = 1'b0, p_last = 1'b0, p_xfer = 1'b0, p_valid = 1'b0;
    logic [7:0] p_data = 8'd0;
    int         m_cnt = 0;
    ent_t       e;
    forever begin
      @(negedge clk);
      if (reset) begin
        p_code = 0; p_last = 0; p_xfer = 0; p_valid = 0; m_cnt = 0; exp_q.delete();
        continue;
      end
      chk("enc_code_ack", enc_code_ack, p_code);
      chk("frame_done", frame_done, p_last);
      if (p_last) chk("enc_rst_with_done", enc_rst, 1);
      if (p_valid && !p_xfer) begin
        chk("tx_valid_hold", tx_valid, 1);
        chk("tx_data_hold", tx_data, p_data);
      end
      chk("byte_count", byte_count, m_cnt);
      n_ack += int'(enc_code_ack); n_done += int'(frame_done); n_rst += int'(enc_rst);
      p_code = 0; p_last = 0;
      p_xfer = tx_valid && tx_ready;
      if (p_xfer) begin
        got_q.push_back(tx_data);
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL extra_byte: got %0h expected no transfer", tx_data);
        end else begin
          e = exp_q.pop_front();
          chk("tx_byte", tx_data, e.b);
          p_code = e.is_code; p_last = e.is_last;
        end
        if (m_cnt < 511) m_cnt++;
      end
      if (go && !busy) m_cnt = 0;
      p_valid = tx_valid; p_data = tx_data;
    end
  end

  // model: build the full expected frame from the stub's contents
  task automatic setup(int n, logic [6:0] r, logic [6:0] c, logic [7:0] p, logic [11:0] a);
    logic [7:0] x;
    ent_t e;
    s_n = n; enc_start_row = r; enc_start_col = c; enc_perimeter = p; enc_area = a;
    exp_q.delete();
    exp_q.push_back('{8'hA5, 1'b0, 1'b0});
    exp_q.push_back('{{1'b0, r}, 1'b0, 1'b0});
    exp_q.push_back('{{1'b0, c}, 1'b0, 1'b0});
    x = {1'b0, r} ^ {1'b0, c};
    for (int i = 0; i < n; i++) begin
      exp_q.push_back('{s_codes[i], 1'b1, 1'b0});
      x ^= s_codes[i];
    end
    exp_q.push_back('{8'h5A, 1'b0, 1'b0});
    exp_q.push_back('{p, 1'b0, 1'b0});
    exp_q.push_back('{{4'b0, a[11:8]}, 1'b0, 1'b0});
    exp_q.push_back('{a[7:0], 1'b0, 1'b0});
    x ^= p ^ {4'b0, a[11:8]} ^ a[7:0];
`ifdef CHAIN_FRAME_CHECKSUM_EN
    exp_q.push_back('{x, 1'b0, 1'b0});
`endif
    e = exp_q.pop_back(); e.is_last = 1'b1; exp_q.push_back(e);
  endtask

  task automatic rand_frame(int n);
    for (int i = 0; i < n; i++) s_codes[i] = 8'($urandom_range(7, 0));
    setup(n, 7'($urandom_range(127, 0)), 7'($urandom_range(127, 0)),
          8'($urandom_range(255, 0)), 12'($urandom_range(4095, 0)));
  endtask

  task automatic launch();
    int t = 0;
    while (busy && t < 500) begin @(negedge clk); t++; end
    @(posedge clk); #1; go = 1'b1;
    @(posedge clk); #1; go = 1'b0;
    @(negedge clk);
    chk("go_enc_start", enc_start, 1);
    chk("go_busy", busy, 1);
    chk("go_frame_error_clear", frame_error, 0);
  endtask

  task automatic wait_end();
    int t = 0;
    while (!(frame_done || enc_rst) && t < 3000) begin @(negedge clk); t++; end
    chk("frame_end_seen", frame_done | enc_rst, 1);
    @(negedge clk);
  endtask

  localparam int L = 3 + 4 + 4
`ifdef CHAIN_FRAME_CHECKSUM_EN
    + 1
`endif
    ;
  logic [7:0] lit [12];
  int a0, d0, r0, t;
  logic seen;

  task automatic check_lit(string name);
    chk(name, got_q.size(), L);
    for (int i = 0; i < L && i < got_q.size(); i++) chk(name, got_q[i], lit[i]);
  endtask

  initial begin
    lit = '{8'hA5, 8'h03, 8'h05, 8'h00, 8'h06, 8'h04, 8'h02, 8'h5A, 8'h04, 8'h00, 8'h04, 8'h06};
    enc_perimeter = 0; enc_area = 0; enc_start_row = 0; enc_start_col = 0;
    repeat (2) @(negedge clk);
    chk("rst_tx_valid", tx_valid, 0);   chk("rst_tx_data", tx_data, 0);
    chk("rst_busy", busy, 0);           chk("rst_enc_start", enc_start, 0);
    chk("rst_enc_rst", enc_rst, 0);     chk("rst_ack", enc_code_ack, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_frame_error", frame_error, 0);
    chk("rst_byte_count", byte_count, 0);
    reset = 1'b0;

    // literal stub frame, zero-wait transmitter
    s_codes[0] = 8'h00; s_codes[1] = 8'h06; s_codes[2] = 8'h04; s_codes[3] = 8'h02;
    tx_mode = 0; s_maxdly = 0; s_mode = 0;
    setup(4, 7'd3, 7'd5, 8'd4, 12'd4);
    got_q.delete(); a0 = n_ack; d0 = n_done; r0 = n_rst;
    launch(); wait_end();
    check_lit("t1_bytes");
    chk("t1_byte_count", byte_count, L);
    chk("t1_acks", n_ack - a0, 4); chk("t1_done", n_done - d0, 1); chk("t1_rst", n_rst - r0, 1);
    chk("t1_busy", busy, 0);

    // same frame, transmitter stalls 10 cycles on code 06
    tx_mode = 2; stall_left = 10;
    setup(4, 7'd3, 7'd5, 8'd4, 12'd4);
    got_q.delete(); a0 = n_ack; d0 = n_done; r0 = n_rst;
    launch(); wait_end();
    check_lit("t2_bytes");
    chk("t2_stall_used", stall_left, 0);
    chk("t2_no_error", frame_error, 0);
    chk("t2_acks", n_ack - a0, 4); chk("t2_done", n_done - d0, 1); chk("t2_rst", n_rst - r0, 1);

    // encoder error in WAIT_FIRST
    tx_mode = 0; s_mode = 1; exp_q.delete();
    got_q.delete(); d0 = n_done; r0 = n_rst;
    launch(); wait_end();
    chk("t3_frame_error", frame_error, 1);
    chk("t3_busy", busy, 0);
    chk("t3_no_bytes", got_q.size(), 0);
    chk("t3_done", n_done - d0, 0); chk("t3_rst", n_rst - r0, 1);
    s_mode = 0; s_maxdly = 4; tx_mode = 1;
    rand_frame(5); launch(); wait_end();     // launch confirms frame_error cleared
    chk("t3_next_ok", frame_error, 0);

    // timeout with encoder never responding
    s_mode = 2; exp_q.delete(); got_q.delete();
    launch();
    t = 0;
    while (!enc_rst && t < 100) begin @(negedge clk); t++; end
    chk("t4_timeout_cycles", t, 16);
    @(negedge clk);
    chk("t4_frame_error", frame_error, 1);
    chk("t4_byte_count", byte_count, 0);
    chk("t4_busy", busy, 0);
    chk("t4_no_bytes", got_q.size(), 0);
    s_mode = 0;

    // reset mid-code
    s_maxdly = 2; tx_mode = 1;
    rand_frame(10); a0 = n_ack;
    launch();
    t = 0;
    while (!(n_ack - a0 >= 2 && tx_valid) && t < 500) begin @(negedge clk); t++; end
    chk("t5_reached_code", tx_valid, 1);
    reset = 1'b1; #1;
    chk("t5_tx_valid", tx_valid, 0); chk("t5_busy", busy, 0);
    chk("t5_byte_count", byte_count, 0); chk("t5_enc_rst", enc_rst, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0; seen = 1'b0;
    repeat (30) begin @(negedge clk); seen = seen | tx_valid | enc_rst | busy; end
    chk("t5_quiet_after_reset", seen, 0);

    // randomized frames
    s_maxdly = 8; tx_mode = 1;
    for (int f = 0; f < 25; f++) begin
      int n = $urandom_range(12, 1);
      rand_frame(n); d0 = n_done; got_q.delete();
      launch(); wait_end();
      chk("rand_done", n_done - d0, 1);
      chk("rand_no_error", frame_error, 0);
      chk("rand_byte_count", byte_count, L - 4 + n);
      chk("rand_queue_drained", exp_q.size(), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
